// File: rtl/cpu_run_pkg.sv
// Shared types for the CPU run-control block: FSM state encoding and counter width.
package cpu_run_pkg;

  localparam int CYCLE_CNT_W = 32;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_IDLE  = 2'd1,
    S_RUN   = 2'd2,
    S_HALT  = 2'd3
  } run_state_t;

endpackage

// File: rtl/switch_sync_debounce.sv
// Two-flop synchronizer plus debouncer for one slide switch.
// Input-to-stable latency is 2 + DEBOUNCE_CYCLES cycles.
module switch_sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic switch_raw,
  output logic switch_stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= '0;
      cnt_q         <= '0;
      switch_stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], switch_raw};
      // Any cycle agreeing with the stable value restarts the qualification window.
      if (sync_q[1] == switch_stable) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        switch_stable <= sync_q[1];
        cnt_q         <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run control: debounced rst/start switches drive a Moore FSM for soft reset and run enable.
// Define CPU_RUN_CYCLE_CNT_EN to build the saturating run-cycle counter; otherwise cycle_cnt_o is 0.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SOFT_RST_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rst_switch_i,
  input  logic                   start_switch_i,
  input  logic                   halt_i,
  output logic                   cpu_rst_o,
  output logic                   cpu_run_o,
  output logic [1:0]             state_o,
  output logic [CYCLE_CNT_W-1:0] cycle_cnt_o
);

  localparam int SR_W = (SOFT_RST_CYCLES > 1) ? $clog2(SOFT_RST_CYCLES) : 1;
  localparam logic [SR_W-1:0] SR_LOAD = SR_W'(SOFT_RST_CYCLES - 1);

  logic       rst_stable;
  logic       start_stable;
  logic       start_prev_q;
  logic       start_rise_q;
  run_state_t state_q;
  run_state_t state_d;
  logic [SR_W-1:0] sr_cnt_q;

  switch_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_rst_sw (
    .clk           (clk),
    .rst           (rst),
    .switch_raw    (rst_switch_i),
    .switch_stable (rst_stable)
  );

  switch_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_start_sw (
    .clk           (clk),
    .rst           (rst),
    .switch_raw    (start_switch_i),
    .switch_stable (start_stable)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_prev_q <= 1'b0;
      start_rise_q <= 1'b0;
    end else begin
      start_prev_q <= start_stable;
      start_rise_q <= start_stable & ~start_prev_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RESET;
      sr_cnt_q <= SR_LOAD;
    end else begin
      state_q <= state_d;
      // Reload only on entry; a switch held high inside S_RESET leaves the count at zero.
      if (state_q != S_RESET && state_d == S_RESET) begin
        sr_cnt_q <= SR_LOAD;
      end else if (state_q == S_RESET && sr_cnt_q != '0) begin
        sr_cnt_q <= sr_cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cpu_rst_o = 1'b0;
    cpu_run_o = 1'b0;
    if (rst_stable) begin
      state_d = S_RESET;
    end else begin
      case (state_q)
        S_RESET: if (sr_cnt_q == '0) state_d = S_IDLE;
        S_IDLE:  if (start_rise_q)   state_d = S_RUN;
        S_RUN:   if (halt_i)         state_d = S_HALT;
        S_HALT:  if (start_rise_q)   state_d = S_RUN;
        default: state_d = S_RESET;
      endcase
    end
    case (state_q)
      S_RESET: cpu_rst_o = 1'b1;
      S_RUN:   cpu_run_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;

`ifdef CPU_RUN_CYCLE_CNT_EN
  logic [CYCLE_CNT_W-1:0] cycle_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= '0;
    end else if (state_q == S_RESET) begin
      cycle_cnt_q <= '0;
    end else if (state_q == S_RUN && cycle_cnt_q != '1) begin
      cycle_cnt_q <= cycle_cnt_q + 1'b1;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
`else
  assign cycle_cnt_o = '0;
`endif

endmodule
